// File: rtl/fm_env_seq_pkg.sv
// Shared types and helpers for the FM envelope sequencer.
package fm_env_seq_pkg;

  localparam int unsigned DEF_NUM_OPS = 36;
  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned OP_W        = 6;
  localparam int unsigned LVL_W       = 9;
  localparam int unsigned RATE_W      = 4;

  localparam logic [LVL_W-1:0] ENV_MAX = 9'd511;

  typedef enum logic [1:0] {
    ENV_ATTACK  = 2'd0,
    ENV_DECAY   = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_e;

  typedef enum logic [1:0] {
    SEQ_INIT,
    SEQ_CLEAR,
    SEQ_IDLE,
    SEQ_SWEEP
  } seq_state_e;

  // One envelope RAM word: {key_prev, state, level}
  typedef struct packed {
    logic             key_prev;
    env_state_e       state;
    logic [LVL_W-1:0] level;
  } env_entry_t;

  // Rate r steps when the low (15-r) counter bits are all zero; r=0 never steps.
  function automatic logic rate_step(input logic [RATE_W-1:0] rate, input logic [14:0] cnt);
    logic [15:0] span;
    span = 16'd1 << (4'd15 - rate);
    return (rate != 4'd0) && ((cnt & 15'(span - 16'd1)) == 15'd0);
  endfunction

endpackage

// File: rtl/fm_env_state_ram.sv
// 64x12 per-operator envelope state store: synchronous write, asynchronous read.
module fm_env_state_ram
  import fm_env_seq_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [OP_W-1:0]  addr_i,
  input  env_entry_t       wdata_i,
  output env_entry_t       rdata_c
);

  env_entry_t mem_q [64];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/fm_env_seq.sv
// Sweeps the operator attribute RAM once per sample tick, advances each operator's
// ADSR envelope and streams one attenuation value per operator.
module fm_env_seq
  import fm_env_seq_pkg::*;
#(
  parameter int unsigned NUM_OPS = DEF_NUM_OPS,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic [63:0] key_on,
  output logic [5:0]  op_sel,
  input  logic        op_egt,
  input  logic [5:0]  op_tl,
  input  logic [3:0]  op_ar,
  input  logic [3:0]  op_dr,
  input  logic [3:0]  op_sl,
  input  logic [3:0]  op_rr,
  output logic        busy,
  output logic        env_valid,
  output logic [5:0]  env_op,
  output logic [8:0]  env_level,
  output logic        overrun
);

  localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPS - 1);

  seq_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_sel_q, op_sel_d;
  logic              busy_q, busy_d;
  logic              env_valid_q, env_valid_d;
  logic [OP_W-1:0]   env_op_q, env_op_d;
  logic [LVL_W-1:0]  env_level_q, env_level_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ram_we;
  env_entry_t        ram_wdata;
  env_entry_t        ram_rdata;
  env_entry_t        env_next;
  logic [LVL_W-1:0]  env_out;

  fm_env_state_ram u_state_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (op_sel_q),
    .wdata_i (ram_wdata),
    .rdata_c (ram_rdata)
  );

  // Envelope update for the operator currently addressed by op_sel.
  always_comb begin : env_calc
    logic              key_c;
    env_state_e        st;
    logic [LVL_W-1:0]  lvl;
    logic [LVL_W-1:0]  dec;
    logic [LVL_W-1:0]  target;
    logic [14:0]       cnt_lo;
    logic [9:0]        sum;

    key_c  = key_on[op_sel_q];
    st     = ram_rdata.state;
    lvl    = ram_rdata.level;
    dec    = (ram_rdata.level >> 3) + 9'd1;
    target = (op_sl == 4'hF) ? ENV_MAX : {op_sl, 5'b0};
    cnt_lo = 15'(cnt_q);

    // Key edges take effect before this visit's rate step.
    if (key_c && !ram_rdata.key_prev)      st = ENV_ATTACK;
    else if (!key_c && ram_rdata.key_prev) st = ENV_RELEASE;

    case (st)
      ENV_ATTACK: begin
        if (op_ar == 4'hF)                lvl = '0;
        else if (rate_step(op_ar, cnt_lo)) lvl = (lvl > dec) ? lvl - dec : '0;
        if (lvl == '0) st = ENV_DECAY;
      end
      ENV_DECAY: begin
        if (rate_step(op_dr, cnt_lo)) begin
          lvl = (lvl == ENV_MAX) ? lvl : lvl + 9'd1;
          if (lvl >= target) st = ENV_SUSTAIN;
        end
      end
      ENV_SUSTAIN: begin
        if (!op_egt && rate_step(op_rr, cnt_lo))
          lvl = (lvl == ENV_MAX) ? lvl : lvl + 9'd1;
      end
      ENV_RELEASE: begin
        if (rate_step(op_rr, cnt_lo))
          lvl = (lvl == ENV_MAX) ? lvl : lvl + 9'd1;
      end
    endcase

    sum      = {1'b0, lvl} + {2'b00, op_tl, 2'b00};
    env_out  = (sum > 10'(ENV_MAX)) ? ENV_MAX : sum[LVL_W-1:0];
    env_next = '{key_prev: key_c, state: st, level: lvl};
  end

  // Sequencer next-state and outputs.
  always_comb begin : seq_fsm
    state_d     = state_q;
    op_sel_d    = op_sel_q;
    busy_d      = busy_q;
    env_valid_d = 1'b0;
    env_op_d    = env_op_q;
    env_level_d = env_level_q;
    overrun_d   = sample_tick & busy_q;
    cnt_d       = cnt_q;
    ram_we      = 1'b0;
    ram_wdata   = env_next;

    case (state_q)
      SEQ_INIT: begin
        state_d  = SEQ_CLEAR;
        busy_d   = 1'b1;
        op_sel_d = '0;
      end
      SEQ_CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = '{key_prev: 1'b0, state: ENV_RELEASE, level: ENV_MAX};
        if (op_sel_q == LAST_OP) begin
          state_d  = SEQ_IDLE;
          busy_d   = 1'b0;
          op_sel_d = '0;
        end else begin
          op_sel_d = op_sel_q + 6'd1;
        end
      end
      SEQ_IDLE: begin
        if (sample_tick) begin
          state_d  = SEQ_SWEEP;
          busy_d   = 1'b1;
          op_sel_d = '0;
        end
      end
      SEQ_SWEEP: begin
        ram_we      = 1'b1;
        env_valid_d = 1'b1;
        env_op_d    = op_sel_q;
        env_level_d = env_out;
        if (op_sel_q == LAST_OP) begin
          state_d  = SEQ_IDLE;
          busy_d   = 1'b0;
          op_sel_d = '0;
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          op_sel_d = op_sel_q + 6'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEQ_INIT;
      op_sel_q    <= '0;
      busy_q      <= 1'b0;
      env_valid_q <= 1'b0;
      env_op_q    <= '0;
      env_level_q <= ENV_MAX;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_sel_q    <= op_sel_d;
      busy_q      <= busy_d;
      env_valid_q <= env_valid_d;
      env_op_q    <= env_op_d;
      env_level_q <= env_level_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  assign op_sel    = op_sel_q;
  assign busy      = busy_q;
  assign env_valid = env_valid_q;
  assign env_op    = env_op_q;
  assign env_level = env_level_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fm_env_seq.sv
// Scoreboard bench for fm_env_seq: a behavioural envelope model predicts every
// env_valid beat of each sweep; the monitor pops and compares in order.
module tb_fm_env_seq;

  localparam int N = 36;
  localparam int ST_ATT = 0;
  localparam int ST_DEC = 1;
  localparam int ST_SUS = 2;
  localparam int ST_REL = 3;

  logic        clk;
  logic        reset;
  logic        sample_tick;
  logic [63:0] key_on;
  logic [5:0]  op_sel;
  logic        op_egt;
  logic [5:0]  op_tl;
  logic [3:0]  op_ar, op_dr, op_sl, op_rr;
  logic        busy, env_valid, overrun;
  logic [5:0]  env_op;
  logic [8:0]  env_level;

  logic        egt_a [64];
  logic [5:0]  tl_a  [64];
  logic [3:0]  ar_a  [64];
  logic [3:0]  dr_a  [64];
  logic [3:0]  sl_a  [64];
  logic [3:0]  rr_a  [64];

  assign op_egt = egt_a[op_sel];
  assign op_tl  = tl_a[op_sel];
  assign op_ar  = ar_a[op_sel];
  assign op_dr  = dr_a[op_sel];
  assign op_sl  = sl_a[op_sel];
  assign op_rr  = rr_a[op_sel];

  fm_env_seq dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .key_on      (key_on),
    .op_sel      (op_sel),
    .op_egt      (op_egt),
    .op_tl       (op_tl),
    .op_ar       (op_ar),
    .op_dr       (op_dr),
    .op_sl       (op_sl),
    .op_rr       (op_rr),
    .busy        (busy),
    .env_valid   (env_valid),
    .env_op      (env_op),
    .env_level   (env_level),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int op;
    int lvl;
  } exp_t;

  exp_t q[$];
  int   obs_env [64];
  int   m_lvl [64];
  int   m_st  [64];
  bit   m_prev[64];
  int   m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_lvl[i]  = 511;
      m_st[i]   = ST_REL;
      m_prev[i] = 1'b0;
    end
    m_cnt = 0;
  endfunction

  function automatic bit gate(int r);
    if (r == 0) return 1'b0;
    return (m_cnt % (1 << (15 - r))) == 0;
  endfunction

  // Predict one full sweep from the attributes/keys presented right now.
  function automatic void push_sweep();
    for (int op = 0; op < N; op++) begin
      logic [5:0] oi;
      int lvl, st, tgt, env;
      bit k;
      exp_t e;
      oi  = 6'(op);
      k   = key_on[oi];
      lvl = m_lvl[oi];
      st  = m_st[oi];
      if (k && !m_prev[oi])      st = ST_ATT;
      else if (!k && m_prev[oi]) st = ST_REL;
      m_prev[oi] = k;
      tgt = (int'(sl_a[oi]) == 15) ? 511 : int'(sl_a[oi]) * 32;
      case (st)
        ST_ATT: begin
          if (int'(ar_a[oi]) == 15) lvl = 0;
          else if (gate(int'(ar_a[oi]))) begin
            lvl = lvl - (lvl / 8 + 1);
            if (lvl < 0) lvl = 0;
          end
          if (lvl == 0) st = ST_DEC;
        end
        ST_DEC: begin
          if (gate(int'(dr_a[oi]))) begin
            if (lvl < 511) lvl = lvl + 1;
            if (lvl >= tgt) st = ST_SUS;
          end
        end
        ST_SUS: begin
          if (!egt_a[oi] && gate(int'(rr_a[oi])) && lvl < 511) lvl = lvl + 1;
        end
        default: begin
          if (gate(int'(rr_a[oi])) && lvl < 511) lvl = lvl + 1;
        end
      endcase
      m_lvl[oi] = lvl;
      m_st[oi]  = st;
      env = lvl + 4 * int'(tl_a[oi]);
      if (env > 511) env = 511;
      e.op  = op;
      e.lvl = env;
      q.push_back(e);
    end
    m_cnt = (m_cnt + 1) % 65536;
  endfunction

  // Output monitor: every env beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (env_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'(env_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("env_op", 32'(env_op), 32'(e.op));
        check("env_level", 32'(env_level), 32'(e.lvl));
        obs_env[env_op] = int'(env_level);
      end
    end
  end

  task automatic run_busy(output int n);
    int guard;
    guard = 0;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic sweep();
    int n;
    @(posedge clk); #1;
    push_sweep();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    run_busy(n);
    check("busy_len", 32'(n), 32'(N));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_op_sel"},    32'(op_sel),    32'd0);
    check({tag, "_env_valid"}, 32'(env_valid), 32'd0);
    check({tag, "_env_op"},    32'(env_op),    32'd0);
    check({tag, "_env_level"}, 32'(env_level), 32'd511);
    check({tag, "_overrun"},   32'(overrun),   32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard;
    reset       = 1'b1;
    sample_tick = 1'b0;
    key_on      = '0;
    for (int i = 0; i < 64; i++) begin
      egt_a[i] = 1'b0; tl_a[i] = '0; ar_a[i] = '0;
      dr_a[i]  = '0;   sl_a[i] = '0; rr_a[i] = '0;
      obs_env[i] = -1;
    end
    model_reset();

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    run_busy(n);
    check("clear_len", 32'(n), 32'(N));

    // Fresh state: every operator released and silent.
    sweep();
    check("first_op0", 32'(obs_env[0]), 32'd511);
    check("first_op35", 32'(obs_env[35]), 32'd511);

    // op3 instant attack with no decay; op7 gated attack/decay in the background.
    ar_a[3] = 4'd15; dr_a[3] = 4'd0; sl_a[3] = 4'd0; egt_a[3] = 1'b1; rr_a[3] = 4'd0;
    key_on[3] = 1'b1;
    ar_a[7] = 4'd12; dr_a[7] = 4'd13; sl_a[7] = 4'd3; rr_a[7] = 4'd14;
    key_on[7] = 1'b1;
    sweep();
    check("op3_attack", 32'(obs_env[3]), 32'd0);
    repeat (3) sweep();
    check("op3_hold", 32'(obs_env[3]), 32'd0);
    tl_a[3] = 6'd10;
    sweep();
    check("op3_tl10", 32'(obs_env[3]), 32'd40);

    // op5 attack -> decay +1 per tick -> sustain at 64.
    ar_a[5] = 4'd15; dr_a[5] = 4'd15; sl_a[5] = 4'd2; egt_a[5] = 1'b1; rr_a[5] = 4'd0;
    key_on[5] = 1'b1;
    sweep();
    check("op5_attack", 32'(obs_env[5]), 32'd0);
    sweep();
    check("op5_decay1", 32'(obs_env[5]), 32'd1);
    repeat (70) sweep();
    check("op5_sustain", 32'(obs_env[5]), 32'd64);

    // Key off with rr=0 freezes; rr=15 climbs one per tick and saturates.
    key_on[5] = 1'b0;
    repeat (3) sweep();
    check("op5_frozen", 32'(obs_env[5]), 32'd64);
    rr_a[5] = 4'd15;
    sweep();
    check("op5_release1", 32'(obs_env[5]), 32'd65);
    repeat (335) sweep();
    check("op5_level400", 32'(obs_env[5]), 32'd400);
    tl_a[5] = 6'd63;
    sweep();
    check("op5_tl_sat", 32'(obs_env[5]), 32'd511);
    tl_a[5] = 6'd0;
    repeat (120) sweep();
    check("op5_level_sat", 32'(obs_env[5]), 32'd511);

    // Tick during a sweep: one overrun pulse, no extra sweep.
    @(posedge clk); #1;
    push_sweep();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (5) @(posedge clk);
    #1 sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(negedge clk);
    check("overrun_pulse", 32'(overrun), 32'd1);
    @(negedge clk);
    check("overrun_clear", 32'(overrun), 32'd0);
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("overrun_sweep_end", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("no_extra_sweep", 32'(busy), 32'd0);
    check("overrun_queue", 32'(q.size()), 32'd0);

    // Reset in the middle of a sweep aborts it; clear sweep follows.
    @(posedge clk); #1;
    push_sweep();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    model_reset();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    run_busy(n);
    check("reclear_len", 32'(n), 32'(N));
    sweep();
    check("post_reset_op0", 32'(obs_env[0]), 32'd511);
    check("post_reset_op3", 32'(obs_env[3]), 32'd40);
    check("post_reset_op5", 32'(obs_env[5]), 32'd511);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
